// File: rtl/game_phase_sequencer.sv
// Phase controller for the whack-a-mole game: sequences the five phase modules,
// arbitrates the shared display/LED bus and guards the timed phases with a watchdog.
module game_phase_sequencer #(
    parameter logic [31:0] WDOG_CYCLES  = 32'd3_000_000_000,
    parameter logic [31:0] BLANK_CYCLES = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic [4:0]  done_in,
    input  logic [39:0] dig_in,
    input  logic [39:0] seg1_in,
    input  logic [39:0] seg2_in,
    input  logic [7:0]  diff_led_sel,
    input  logic [7:0]  diff_led_over,
    input  logic [31:0] state_led_in,
    output logic [4:0]  phase_en,
    output logic [4:0]  phase_start,
    output logic [2:0]  phase,
    output logic [7:0]  dig_display,
    output logic [7:0]  seg_code_1,
    output logic [7:0]  seg_code_2,
    output logic [7:0]  diff_led_show,
    output logic [7:0]  state_led_show,
    output logic        timeout_err
);

    localparam logic [2:0] S_SELECT = 3'd0;
    localparam logic [2:0] S_READY  = 3'd1;
    localparam logic [2:0] S_COUNT  = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;
    localparam logic [2:0] S_BLANK  = 3'd5;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [31:0] cnt;
    logic        started;
    logic        done_ok;
    logic        timed;
    logic        wdog_fire;
    logic        blank_done;
    logic [7:0]  dig_sel;
    logic [7:0]  seg1_sel;
    logic [7:0]  seg2_sel;
    logic [7:0]  diff_sel;
    logic [7:0]  sled_sel;

    function automatic logic [4:0] phase_onehot(input logic [2:0] s);
        case (s)
            S_SELECT: phase_onehot = 5'b00001;
            S_READY:  phase_onehot = 5'b00010;
            S_COUNT:  phase_onehot = 5'b00100;
            S_PLAY:   phase_onehot = 5'b01000;
            S_OVER:   phase_onehot = 5'b10000;
            default:  phase_onehot = 5'b00000;
        endcase
    endfunction

    assign phase = state;

    // A done level counts only once the phase has had its start cycle.
    always_comb begin
        done_ok    = started && (phase_start == 5'b00000);
        timed      = (state == S_READY) || (state == S_COUNT) || (state == S_OVER);
        wdog_fire  = timed && !abort && (cnt == WDOG_CYCLES - 32'd1);
        blank_done = !abort && (cnt == BLANK_CYCLES - 32'd1);
    end

    always_comb begin
        next_state = state;
        case (state)
            S_SELECT: begin
                if (abort)                       next_state = S_BLANK;
                else if (done_ok && done_in[0])  next_state = S_READY;
            end
            S_READY: begin
                if (abort || wdog_fire)          next_state = S_BLANK;
                else if (done_ok && done_in[1])  next_state = S_COUNT;
            end
            S_COUNT: begin
                if (abort || wdog_fire)          next_state = S_BLANK;
                else if (done_ok && done_in[2])  next_state = S_PLAY;
            end
            S_PLAY: begin
                if (abort)                       next_state = S_BLANK;
                else if (done_ok && done_in[3])  next_state = S_OVER;
            end
            S_OVER: begin
                if (abort || wdog_fire)          next_state = S_BLANK;
                else if (done_ok && done_in[4])  next_state = S_BLANK;
            end
            S_BLANK: begin
                if (blank_done)                  next_state = S_SELECT;
            end
            default: next_state = S_BLANK;
        endcase
    end

    always_comb begin
        dig_sel  = '0;
        seg1_sel = '0;
        seg2_sel = '0;
        diff_sel = '0;
        sled_sel = '0;
        case (state)
            S_SELECT: begin
                dig_sel  = dig_in[7:0];
                seg1_sel = seg1_in[7:0];
                seg2_sel = seg2_in[7:0];
                diff_sel = diff_led_sel;
            end
            S_READY: begin
                dig_sel  = dig_in[15:8];
                seg1_sel = seg1_in[15:8];
                seg2_sel = seg2_in[15:8];
                diff_sel = diff_led_sel;
                sled_sel = state_led_in[7:0];
            end
            S_COUNT: begin
                dig_sel  = dig_in[23:16];
                seg1_sel = seg1_in[23:16];
                seg2_sel = seg2_in[23:16];
                diff_sel = diff_led_sel;
                sled_sel = state_led_in[15:8];
            end
            S_PLAY: begin
                dig_sel  = dig_in[31:24];
                seg1_sel = seg1_in[31:24];
                seg2_sel = seg2_in[31:24];
                diff_sel = diff_led_sel;
                sled_sel = state_led_in[23:16];
            end
            S_OVER: begin
                dig_sel  = dig_in[39:32];
                seg1_sel = seg1_in[39:32];
                seg2_sel = seg2_in[39:32];
                diff_sel = diff_led_over;
                sled_sel = state_led_in[31:24];
            end
            default: ;
        endcase
    end

    // One shared counter serves as watchdog in timed phases and blank timer in BLANK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_SELECT;
            cnt            <= '0;
            started        <= 1'b0;
            phase_en       <= '0;
            phase_start    <= '0;
            timeout_err    <= 1'b0;
            dig_display    <= '0;
            seg_code_1     <= '0;
            seg_code_2     <= '0;
            diff_led_show  <= '0;
            state_led_show <= '0;
        end else begin
            started <= 1'b1;
            state   <= next_state;

            if (next_state != state)
                cnt <= '0;
            else if ((state == S_BLANK) && abort)
                cnt <= '0;
            else if ((timed || (state == S_BLANK)) && (cnt != '1))
                cnt <= cnt + 32'd1;

            phase_en <= phase_onehot(next_state);
            if ((next_state != state) || !started)
                phase_start <= phase_onehot(next_state);
            else
                phase_start <= '0;

            if ((next_state == S_SELECT) && (state != S_SELECT))
                timeout_err <= 1'b0;
            else if (wdog_fire)
                timeout_err <= 1'b1;

            dig_display    <= dig_sel;
            seg_code_1     <= seg1_sel;
            seg_code_2     <= seg2_sel;
            diff_led_show  <= diff_sel;
            state_led_show <= sled_sel;
        end
    end

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed bench for game_phase_sequencer with WDOG_CYCLES=16 and BLANK_CYCLES=4;
// inputs change and outputs are sampled 1 ns after each rising edge.
module tb_game_phase_sequencer;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic [4:0]  done_in;
    logic [39:0] dig_in;
    logic [39:0] seg1_in;
    logic [39:0] seg2_in;
    logic [7:0]  diff_led_sel;
    logic [7:0]  diff_led_over;
    logic [31:0] state_led_in;
    logic [4:0]  phase_en;
    logic [4:0]  phase_start;
    logic [2:0]  phase;
    logic [7:0]  dig_display;
    logic [7:0]  seg_code_1;
    logic [7:0]  seg_code_2;
    logic [7:0]  diff_led_show;
    logic [7:0]  state_led_show;
    logic        timeout_err;

    int checks;
    int errors;

    game_phase_sequencer #(
        .WDOG_CYCLES  (32'd16),
        .BLANK_CYCLES (32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .abort          (abort),
        .done_in        (done_in),
        .dig_in         (dig_in),
        .seg1_in        (seg1_in),
        .seg2_in        (seg2_in),
        .diff_led_sel   (diff_led_sel),
        .diff_led_over  (diff_led_over),
        .state_led_in   (state_led_in),
        .phase_en       (phase_en),
        .phase_start    (phase_start),
        .phase          (phase),
        .dig_display    (dig_display),
        .seg_code_1     (seg_code_1),
        .seg_code_2     (seg_code_2),
        .diff_led_show  (diff_led_show),
        .state_led_show (state_led_show),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        abort = 1'b0;
        done_in = '0;
        repeat (3) step();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        checks++; if (phase_en !== 5'b0) begin errors++; $display("FAIL reset_en got=%b exp=00000", phase_en); end
        checks++; if (phase_start !== 5'b0) begin errors++; $display("FAIL reset_start got=%b exp=00000", phase_start); end
        checks++; if (dig_display !== 8'h00) begin errors++; $display("FAIL reset_dig got=%h exp=00", dig_display); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got=%b exp=0", timeout_err); end
        rst_n = 1'b1;
        step();
        checks++; if (phase_start !== 5'b00001) begin errors++; $display("FAIL rel_start got=%b exp=00001", phase_start); end
        checks++; if (phase_en !== 5'b00001) begin errors++; $display("FAIL rel_en got=%b exp=00001", phase_en); end
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rel_phase got=%0d exp=0", phase); end
        checks++; if (dig_display !== 8'h10) begin errors++; $display("FAIL rel_dig got=%h exp=10", dig_display); end
        step();
        checks++; if (phase_start !== 5'b00000) begin errors++; $display("FAIL rel_start2 got=%b exp=00000", phase_start); end
        checks++; if (phase_en !== 5'b00001) begin errors++; $display("FAIL rel_en2 got=%b exp=00001", phase_en); end
    endtask

    task automatic test_sequence();
        logic [4:0] exp_start;
        logic [7:0] exp_seg;
        for (int k = 0; k < 5; k++) begin
            done_in = 5'(1 << k);
            step();
            exp_start = (k < 4) ? 5'(1 << (k + 1)) : 5'b0;
            checks++; if (phase !== 3'(k + 1)) begin errors++; $display("FAIL seq_phase k=%0d got=%0d exp=%0d", k, phase, k + 1); end
            checks++; if (phase_start !== exp_start) begin errors++; $display("FAIL seq_start k=%0d got=%b exp=%b", k, phase_start, exp_start); end
            if (k == 4) begin
                // OVER byte still visible on the first BLANK cycle.
                checks++; if (seg_code_1 !== 8'h24) begin errors++; $display("FAIL seq_seg_over got=%h exp=24", seg_code_1); end
                checks++; if (diff_led_show !== 8'h5A) begin errors++; $display("FAIL seq_diff_over got=%h exp=5a", diff_led_show); end
                done_in = '0;
            end else begin
                step();
                exp_seg = 8'h20 + 8'(k + 1);
                checks++; if (phase_start !== 5'b0) begin errors++; $display("FAIL seq_start_off k=%0d got=%b exp=00000", k, phase_start); end
                checks++; if (seg_code_1 !== exp_seg) begin errors++; $display("FAIL seq_seg k=%0d got=%h exp=%h", k, seg_code_1, exp_seg); end
                checks++; if (state_led_show !== 8'h40 + 8'(k + 1)) begin errors++; $display("FAIL seq_sled k=%0d got=%h exp=%h", k, state_led_show, 8'h40 + 8'(k + 1)); end
                step();
                checks++; if (phase !== 3'(k + 1)) begin errors++; $display("FAIL seq_hold k=%0d got=%0d exp=%0d", k, phase, k + 1); end
                done_in = '0;
            end
        end
    endtask

    task automatic test_blank();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (phase !== 3'd5) begin errors++; $display("FAIL blank_phase i=%0d got=%0d exp=5", i, phase); end
            checks++; if ({phase_en, phase_start} !== 10'b0) begin errors++; $display("FAIL blank_en i=%0d got=%b exp=0", i, {phase_en, phase_start}); end
            checks++; if ({dig_display, seg_code_1, seg_code_2, diff_led_show, state_led_show} !== 40'h0) begin
                errors++; $display("FAIL blank_disp i=%0d got=%h exp=0", i, {dig_display, seg_code_1, seg_code_2, diff_led_show, state_led_show});
            end
        end
        step();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL blank_exit got=%0d exp=0", phase); end
        checks++; if (phase_start !== 5'b00001) begin errors++; $display("FAIL blank_exit_start got=%b exp=00001", phase_start); end
        checks++; if (dig_display !== 8'h00) begin errors++; $display("FAIL blank_exit_dig got=%h exp=00", dig_display); end
        step();
        checks++; if (dig_display !== 8'h10) begin errors++; $display("FAIL sel_dig got=%h exp=10", dig_display); end
        checks++; if (diff_led_show !== 8'hA5) begin errors++; $display("FAIL sel_diff got=%h exp=a5", diff_led_show); end
    endtask

    task automatic test_watchdog();
        int waited;
        done_in = 5'b00001;
        step();
        done_in = '0;
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL wd_enter got=%0d exp=1", phase); end
        repeat (15) step();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL wd_early got=%0d exp=1", phase); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early_tmo got=%b exp=0", timeout_err); end
        step();
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL wd_fire got=%0d exp=5", phase); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_tmo got=%b exp=1", timeout_err); end
        waited = 0;
        while (phase !== 3'd0 && waited < 10) begin
            step();
            waited++;
            if (phase === 3'd5) begin
                checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", timeout_err); end
            end
        end
        checks++; if (waited !== 4) begin errors++; $display("FAIL wd_blank_len got=%0d exp=4", waited); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", timeout_err); end
        step();
    endtask

    task automatic test_entry_ignore();
        done_in = 5'b00001;
        step();
        done_in = 5'b00010;
        step();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL entry_ignore got=%0d exp=1", phase); end
        step();
        checks++; if (phase !== 3'd2) begin errors++; $display("FAIL entry_next got=%0d exp=2", phase); end
    endtask

    task automatic test_count_ignore();
        done_in = 5'b01000;
        repeat (3) begin
            step();
            checks++; if (phase !== 3'd2) begin errors++; $display("FAIL count_ignore got=%0d exp=2", phase); end
        end
        done_in = 5'b00100;
        step();
        done_in = '0;
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL count_exit got=%0d exp=3", phase); end
    endtask

    task automatic test_abort_play();
        step();
        checks++; if (state_led_show !== 8'h43) begin errors++; $display("FAIL play_sled got=%h exp=43", state_led_show); end
        abort = 1'b1;
        done_in = 5'b01000;
        step();
        abort = 1'b0;
        done_in = '0;
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL abort_phase got=%0d exp=5", phase); end
        checks++; if (phase_en !== 5'b0) begin errors++; $display("FAIL abort_en got=%b exp=00000", phase_en); end
        step();
        checks++; if (state_led_show !== 8'h00) begin errors++; $display("FAIL abort_sled got=%h exp=00", state_led_show); end
    endtask

    task automatic test_abort_blank();
        abort = 1'b1;
        repeat (6) step();
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL ab_hold got=%0d exp=5", phase); end
        abort = 1'b0;
        repeat (3) step();
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL ab_restart got=%0d exp=5", phase); end
        step();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL ab_exit got=%0d exp=0", phase); end
        step();
    endtask

    task automatic test_reset_mid();
        done_in = 5'b00001;
        step();
        done_in = '0;
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL mid_phase got=%0d exp=0", phase); end
        checks++; if ({phase_en, phase_start, dig_display} !== 18'h0) begin errors++; $display("FAIL mid_outs got=%h exp=0", {phase_en, phase_start, dig_display}); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (phase_start !== 5'b00001) begin errors++; $display("FAIL mid_rel got=%b exp=00001", phase_start); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        abort = 1'b0;
        done_in = '0;
        dig_in  = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        seg1_in = {8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
        seg2_in = {8'h34, 8'h33, 8'h32, 8'h31, 8'h30};
        diff_led_sel  = 8'hA5;
        diff_led_over = 8'h5A;
        state_led_in  = {8'h44, 8'h43, 8'h42, 8'h41};
        test_reset();
        test_sequence();
        test_blank();
        test_watchdog();
        test_entry_ignore();
        test_count_ignore();
        test_abort_play();
        test_abort_blank();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
